alu_op_issue: RTL
=================

// Module: alu_op_issue
// PURPOSE
// Decode/issue stage that drives the ALU's operation/operand1/operand2 inputs. Takes one RV32I
// instruction with its register operands and PC, and produces the 4-bit ALU opcode plus both operands.
// Results go through a 2-entry valid/ready buffer, so upstream fetch/regfile and the downstream
// execute stage can stall independently.
// PARAMETERS
// ADDOP 4'b0001  SUBOP 4'b0010  ANDOP 4'b0011  ORWOP 4'b0100  SLLOP 4'b0101 : ALU opcode encodings
// SRLOP 4'b0110  XOROP 4'b0111  SLTOP 4'b1000  JALOP 4'b1001  LUIOP 4'b1010 : ALU opcode encodings
// DEPTH 2 : buffer entries (fixed at 2; other values unsupported)
// PORTS
// clk          in   1   rising-edge clock
// rst_n        in   1   asynchronous reset, active low
// flush        in   1   synchronous: discard all buffered entries
// in_valid     in   1   instruction/operands valid
// in_ready     out  1   buffer can accept this cycle
// in_inst      in   32  RV32I instruction word
// in_rs1       in   32  rs1 register value
// in_rs2       in   32  rs2 register value
// in_pc        in   32  instruction PC
// out_valid    out  1   head entry valid
// out_ready    in   1   execute stage consumes head
// out_op       out  4   ALU operation (0000 = illegal/none)
// out_operand1 out  32  ALU operand1
// out_operand2 out  32  ALU operand2
// out_illegal  out  1   head instruction not supported
// occupancy    out  2   entries held (0..2)
// BEHAVIOUR
// Reset (async, rst_n=0): occupancy=0, out_valid=0, all out_* data=0, in_ready=1.
// - in_ready = (occupancy!=2); it is combinational from registered state only, never from in_valid.
// - Accept occurs on in_valid&&in_ready. Pop occurs on out_valid&&out_ready.
// - Latency: an instruction accepted into an empty buffer sets out_valid on the next rising edge.
// - FIFO order is strict. Head outputs stay stable while out_valid&&!out_ready.
// - occ=1 with accept and pop in the same cycle: occ stays 1; the new entry is head next cycle.
// - occ=2: no accept; a pop gives occ=1 and the second entry becomes head.
// - flush: occ becomes 0, out_valid=0 and data is zeroed. flush wins over a same-cycle accept/pop.
// Decode (opc=inst[6:0], f3=inst[14:12], f7=inst[31:25], immI/S sign-extended to 32 bits):
// - 0110011 R: f3 000/f7 00: ADD; 000/20: SUB; 111: AND; 110: OR; 100: XOR; 010: SLT;
//   001/f7 00: SLL; 101/f7 00: SRL. op1=rs1, op2=rs2.
// - 0010011 I: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT; op1=rs1, op2=immI.
//   001/f7 00 SLL and 101/f7 00 SRL use op2={27'b0,inst[24:20]}.
// - 0000011 load: ADD, op1=rs1, op2=immI. 0100011 store: ADD, op1=rs1, op2=immS.
// - 1100011 branch: SUB, op1=rs1, op2=rs2 (the ALU zeroFlag feeds branch resolution).
// - 1101111 JAL and 1100111 JALR: JALOP, op1=0, op2=pc (the ALU returns pc+4 as the link value).
// - 0110111 LUI: LUIOP, op1=0, op2={inst[31:12],12'b0}.
// - Anything else, including SRA/SRAI and bad f7: op=0000, operands=0, illegal=1.
//   The entry still passes through the handshake like any other.
// TESTING
// 1 reset low mid-stream with occ=2 -> next cycle occ=0, out_valid=0, out_op=0, in_ready=1.
// 2 add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle op=0001, op1=5, op2=7.
// 3 addi imm=-1 (0xFFF08093), rs1=10 -> op=0001, op2=0xFFFFFFFF. lui 0x12345 -> op=1010, op2=0x12345000.
// 4 jal at pc=0x100 -> op=1001, op2=0x100. Opcode 0x7F -> op=0000, illegal=1.
// 5 out_ready=0, push 3 back-to-back -> in_ready=0 after 2; head stable; release -> 3 out in order.
// 6 occ=1, flush with in_valid=1 same cycle -> occ=0, out_valid=0, accepted entry discarded.

Source files
------------

// File: rtl/alu_op_issue.sv
// RV32I decode/issue stage: maps an instruction to an ALU opcode and two operands,
// then holds up to two decoded entries in a valid/ready skid buffer for the execute stage.
module alu_op_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [31:0] out_operand1,
  output logic [31:0] out_operand2,
  output logic        out_illegal,
  output logic [1:0]  occupancy
);

  // state   | meaning
  // S_EMPTY | no entries held, outputs zero
  // S_ONE   | head entry valid, tail empty
  // S_FULL  | head and tail valid, upstream stalled

  localparam logic [3:0] ADDOP = 4'b0001;
  localparam logic [3:0] SUBOP = 4'b0010;
  localparam logic [3:0] ANDOP = 4'b0011;
  localparam logic [3:0] ORWOP = 4'b0100;
  localparam logic [3:0] SLLOP = 4'b0101;
  localparam logic [3:0] SRLOP = 4'b0110;
  localparam logic [3:0] XOROP = 4'b0111;
  localparam logic [3:0] SLTOP = 4'b1000;
  localparam logic [3:0] JALOP = 4'b1001;
  localparam logic [3:0] LUIOP = 4'b1010;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // entry layout: {illegal, op[3:0], operand1[31:0], operand2[31:0]}
  localparam int EW = 69;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic [EW-1:0] r_head, r_tail;
  logic [EW-1:0] w_head_nxt, w_tail_nxt;
  logic [EW-1:0] w_new;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [3:0]  w_dec_op;
  logic [31:0] w_dec_op1;
  logic [31:0] w_dec_op2;
  logic        w_accept;
  logic        w_pop;
  logic        w_unused_rs1_field;

  assign w_opc   = in_inst[6:0];
  assign w_f3    = in_inst[14:12];
  assign w_f7    = in_inst[31:25];
  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  // register fields arrive already resolved as in_rs1/in_rs2
  assign w_unused_rs1_field = ^in_inst[19:15];

  always_comb begin
    w_dec_op  = 4'b0000;
    w_dec_op1 = in_rs1;
    w_dec_op2 = in_rs2;
    case (w_opc)
      OPC_R: begin
        case (w_f3)
          3'b000: begin
            if (w_f7 == F7_ZERO)     w_dec_op = ADDOP;
            else if (w_f7 == F7_ALT) w_dec_op = SUBOP;
          end
          3'b111: w_dec_op = ANDOP;
          3'b110: w_dec_op = ORWOP;
          3'b100: w_dec_op = XOROP;
          3'b010: w_dec_op = SLTOP;
          3'b001: if (w_f7 == F7_ZERO) w_dec_op = SLLOP;
          3'b101: if (w_f7 == F7_ZERO) w_dec_op = SRLOP;
          default: w_dec_op = 4'b0000;
        endcase
      end
      OPC_I: begin
        w_dec_op2 = w_imm_i;
        case (w_f3)
          3'b000: w_dec_op = ADDOP;
          3'b111: w_dec_op = ANDOP;
          3'b110: w_dec_op = ORWOP;
          3'b100: w_dec_op = XOROP;
          3'b010: w_dec_op = SLTOP;
          3'b001: begin
            w_dec_op2 = {27'b0, in_inst[24:20]};
            if (w_f7 == F7_ZERO) w_dec_op = SLLOP;
          end
          3'b101: begin
            w_dec_op2 = {27'b0, in_inst[24:20]};
            if (w_f7 == F7_ZERO) w_dec_op = SRLOP;
          end
          default: w_dec_op = 4'b0000;
        endcase
      end
      OPC_LOAD: begin
        w_dec_op  = ADDOP;
        w_dec_op2 = w_imm_i;
      end
      OPC_STORE: begin
        w_dec_op  = ADDOP;
        w_dec_op2 = w_imm_s;
      end
      OPC_BRANCH: w_dec_op = SUBOP;
      OPC_JAL, OPC_JALR: begin
        w_dec_op  = JALOP;
        w_dec_op1 = 32'b0;
        w_dec_op2 = in_pc;
      end
      OPC_LUI: begin
        w_dec_op  = LUIOP;
        w_dec_op1 = 32'b0;
        w_dec_op2 = {in_inst[31:12], 12'b0};
      end
      default: w_dec_op = 4'b0000;
    endcase
  end

  // unsupported encodings travel as an all-zero entry flagged illegal
  assign w_new = (w_dec_op == 4'b0000) ? {1'b1, 4'b0000, 64'b0}
                                       : {1'b0, w_dec_op, w_dec_op1, w_dec_op2};

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = S_ONE;
            w_head_nxt  = w_new;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            w_head_nxt = w_new;
          end else if (w_accept) begin
            w_state_nxt = S_FULL;
            w_tail_nxt  = w_new;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
            w_head_nxt  = '0;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_nxt = S_ONE;
            w_head_nxt  = r_tail;
            w_tail_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
          w_head_nxt  = '0;
          w_tail_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  assign out_illegal  = r_head[68];
  assign out_op       = r_head[67:64];
  assign out_operand1 = r_head[63:32];
  assign out_operand2 = r_head[31:0];
  assign occupancy    = r_state;

endmodule
